// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
//   Shared constants and types for the PWM capture block.
//   - PWM_RESOLUTION : default counter resolution in bits; the measurement
//                      counter itself is one bit wider (pwm_cnt_w()).
//   - cap_state_e    : capture FSM states.
// ---------------------------------------------------------------------------
package pwm_pkg;

    localparam int PWM_RESOLUTION = 8;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,   // waiting for the first rising edge
        HIGH    = 2'd1,   // counting the high phase
        LOW     = 2'd2,   // counting the low phase
        STUCK   = 2'd3    // no edge for MAX clocks; counter frozen
    } cap_state_e;

    // Width of the period/high counters for a given resolution.
    function automatic int pwm_cnt_w(input int res);
        return res + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser bringing an asynchronous level into i_clk.
//   Ports:
//     i_clk   : destination clock
//     i_rst_n : asynchronous active-low reset, clears both flops
//     i_d     : asynchronous input level
//     o_q     : synchronised level (2 clocks of latency)
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta <= 1'b0;
            o_q  <= 1'b0;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//   Measures an asynchronous PWM waveform: the number of clocks between
//   consecutive rising edges (period) and the number of clocks the line was
//   high within that period. Reports with a one-cycle o_valid strobe; a line
//   that shows no edge for MAX = 2^(RESOLUTION+1)-1 clocks is reported as
//   stuck (o_stuck=1, o_period=0, o_high=MAX or 0).
//
//   Parameters:
//     RESOLUTION : counter resolution; outputs are RESOLUTION+1 bits wide.
//   Ports:
//     i_clk    : clock, all logic on rising edge
//     i_rst_n  : asynchronous active-low reset
//     i_pwm    : PWM input, asynchronous to i_clk
//     o_period : clocks between consecutive rising edges (0 when stuck)
//     o_high   : clocks high within that period (MAX/0 when stuck high/low)
//     o_valid  : one-cycle strobe, outputs updated
//     o_stuck  : 1 = no edge for MAX clocks
//
//   Build option:
//     PWM_CAPTURE_GLITCH_FILTER_EN : when defined, a level change is accepted
//       only after two consecutive identical synchronised samples, so 1-clock
//       pulses are dropped at the cost of one extra cycle of latency.
// ---------------------------------------------------------------------------
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int RESOLUTION = PWM_RESOLUTION
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_pwm,
    output logic [RESOLUTION:0]   o_period,
    output logic [RESOLUTION:0]   o_high,
    output logic                  o_valid,
    output logic                  o_stuck
);

    localparam int            CW  = pwm_cnt_w(RESOLUTION);
    localparam logic [CW-1:0] MAX = {CW{1'b1}};
    localparam logic [CW-1:0] ONE = CW'(1);

    // -----------------------------------------------------------------------
    // Input conditioning
    // -----------------------------------------------------------------------
    logic pwm_sync;   // synchronised line
    logic pwm_lvl;    // last accepted level; edges are changes against it
    logic accept;     // current sample may be taken as the new level
    logic rise;
    logic fall;

    sync_2ff u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_pwm),
        .o_q     (pwm_sync)
    );

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // A change only counts once the synchronised line has shown the same
    // value on two consecutive clocks; a single-clock pulse never does.
    logic pwm_sync_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pwm_sync_d <= 1'b0;
            pwm_lvl    <= 1'b0;
        end else begin
            pwm_sync_d <= pwm_sync;
            if (accept)
                pwm_lvl <= pwm_sync;
        end
    end

    assign accept = (pwm_sync == pwm_sync_d);
`else
    // Unfiltered: the accepted level is simply the one-cycle-delayed copy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            pwm_lvl <= 1'b0;
        else
            pwm_lvl <= pwm_sync;
    end

    assign accept = 1'b1;
`endif

    assign rise = accept &  pwm_sync & ~pwm_lvl;
    assign fall = accept & ~pwm_sync &  pwm_lvl;

    // -----------------------------------------------------------------------
    // Capture FSM with registered report outputs
    // -----------------------------------------------------------------------
    // The counter is loaded with 1 in the cycle a rising edge is seen and
    // increments every cycle after, so on the next edge it holds exactly the
    // number of clocks elapsed since the rising edge.
    cap_state_e     state;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  high_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ACQUIRE;
            cnt      <= '0;
            high_cnt <= '0;
            o_period <= '0;
            o_high   <= '0;
            o_valid  <= 1'b0;
            o_stuck  <= 1'b0;
        end else begin
            o_valid <= 1'b0;

            case (state)
                // Partial periods are never reported: wait for a rising edge
                // to start a full measurement.
                ACQUIRE: begin
                    if (rise) begin
                        cnt   <= ONE;
                        state <= HIGH;
                    end
                end

                HIGH: begin
                    if (fall) begin
                        high_cnt <= cnt;
                        cnt      <= (cnt == MAX) ? cnt : cnt + ONE;
                        state    <= LOW;
                    end else if (cnt == MAX) begin
                        o_period <= '0;
                        o_high   <= MAX;
                        o_stuck  <= 1'b1;
                        o_valid  <= 1'b1;
                        state    <= STUCK;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end

                LOW: begin
                    if (rise) begin
                        o_period <= cnt;
                        o_high   <= high_cnt;
                        o_stuck  <= 1'b0;
                        o_valid  <= 1'b1;
                        cnt      <= ONE;
                        state    <= HIGH;
                    end else if (cnt == MAX) begin
                        o_period <= '0;
                        o_high   <= '0;
                        o_stuck  <= 1'b1;
                        o_valid  <= 1'b1;
                        state    <= STUCK;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end

                // Counter frozen. A rising edge starts a fresh measurement
                // right away; a falling edge (leaving stuck-high) has no
                // valid period start, so go back to acquiring.
                STUCK: begin
                    if (rise) begin
                        cnt   <= ONE;
                        state <= HIGH;
                    end else if (fall) begin
                        state <= ACQUIRE;
                    end
                end

                default: state <= ACQUIRE;
            endcase
        end
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter: RESOLUTION, default 8, width in bits of the measured PWM counter (measured values use RESOLUTION+1 bits).
REQ-002 SHALL have port: i_clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_pwm  input  1  PWM waveform, asynchronous to i_clk.
REQ-005 SHALL have port: o_period  output  RESOLUTION+1  clocks between consecutive rising edges.
REQ-006 SHALL have port: o_high  output  RESOLUTION+1  clocks the line was high within that period.
REQ-007 SHALL have port: o_valid  output  1  one-cycle strobe, o_period/o_high/o_stuck updated.
REQ-008 SHALL have port: o_stuck  output  1  1 = no edge for MAX clocks (0% or 100% duty).

Function
REQ-009 SHALL synchronise i_pwm through two flops; edges are detected by comparing the synchronised level with its one-cycle-delayed copy.
REQ-010 SHALL use a RESOLUTION+1-bit counter that saturates at MAX = 2^(RESOLUTION+1)-1.
REQ-011 SHALL implement the states ACQUIRE, HIGH, LOW and STUCK; reset state is ACQUIRE.
REQ-012 ACQUIRE: ignore falling edges; on a rising edge go to HIGH and load counter with 1; no o_valid.
REQ-013 HIGH: increment the counter; on a falling edge latch high_count = counter and go to LOW.
REQ-014 LOW: increment the counter; on a rising edge drive o_period = counter, o_high = high_count, o_stuck = 0, pulse o_valid, load counter with 1 and go to HIGH.
REQ-015 Counter semantics: a waveform with rising edges P clocks apart and H clocks high SHALL report o_period = P and o_high = H exactly.
REQ-016 In HIGH or LOW, when the counter reaches MAX with no edge, SHALL drive o_stuck = 1, o_period = 0, o_high = MAX if the line is high and 0 if low, pulse o_valid, and go to STUCK.
REQ-017 STUCK: hold the counter; a rising edge goes to HIGH (counter = 1, no o_valid); a falling edge goes to ACQUIRE.
REQ-018 o_valid SHALL be high for exactly one cycle per report and SHALL be asserted 3 clock edges after the first edge that samples the new i_pwm level (2 sync + 1 output register).
REQ-019 o_period, o_high and o_stuck SHALL hold their values between o_valid strobes.
REQ-020 The first complete period after ACQUIRE or STUCK SHALL be reported; partial periods SHALL NOT be reported.

Reset
REQ-021 Asserting i_rst_n low SHALL immediately clear o_period, o_high, o_valid, o_stuck, the counter, high_count and the synchroniser flops, and SHALL force ACQUIRE, including mid-period.
REQ-022 After deassertion, the block SHALL wait for a rising edge on the synchronised line before counting.

Configuration
REQ-023 Macro PWM_CAPTURE_GLITCH_FILTER_EN defined: a level change SHALL be accepted only after two consecutive identical synchronised samples, adding 1 cycle of latency (4 edges); pulses of 1 clock SHALL be ignored.
REQ-024 Macro PWM_CAPTURE_GLITCH_FILTER_EN undefined: no filter, with latency as in REQ-018.

Structure
REQ-025 Package pwm_pkg SHALL hold the default RESOLUTION constant and the capture state enum (ACQUIRE, HIGH, LOW, STUCK).
REQ-026 The two-flop synchroniser SHALL be a separate sub-module, sync_2ff, with the reset clearing both flops.

Verification (RESOLUTION=8)
REQ-027 Drive i_pwm with period 10 and high time 3 (top=9, compare=3) -> after the first full period, o_valid every 10 clocks with o_period=10, o_high=3, o_stuck=0.
REQ-028 Drive period 256 with high time 256 (100% duty) held steady -> after 511 clocks in HIGH, a single o_valid with o_stuck=1, o_high=511, o_period=0; no further strobes.
REQ-029 Hold i_pwm low from reset, then apply period 4 and high time 1 -> no o_valid until the second rising edge, then o_period=4, o_high=1.
REQ-030 Assert i_rst_n mid-LOW at period 10 -> all outputs become 0 in the same cycle; after release, the first report occurs only after two rising edges.
REQ-031 Insert a 1-clock high glitch into a low phase -> with PWM_CAPTURE_GLITCH_FILTER_EN, reports are unchanged; without it, an extra o_valid reports the glitch period.
